// File: rtl/oam_dma_pkg.sv
// Shared constants, state encoding and helpers for the OAM DMA engine.
// The optional OAM_DMA_ECHO_EN build uses echo_hi() to fold E0-FF sources onto C0-DF.
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
    localparam int          XFER_LEN_DEFAULT     = 160;
    localparam logic [15:0] HRAM_LO              = 16'hFF80;
    localparam logic [15:0] HRAM_HI              = 16'hFFFE;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t RD    = 2'd2;
    localparam state_t WR    = 2'd3;

    function automatic logic [7:0] echo_hi(input logic [7:0] hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/oam_dma_cpu_gate.sv
// CPU-side bus multiplexer: full pass-through when idle, HRAM/DMA-register only while a
// transfer runs. The DMA owns the bus during its read cycle; CPU accesses wait for START/WR.
module oam_dma_cpu_gate
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT
) (
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        dma_active,
    input  logic        dma_rd,
    input  logic [15:0] dma_bus_a,
    input  logic [7:0]  src_hi,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_rd,
    output logic        bus_wr
);

    logic is_reg;
    logic is_hram;
    logic cpu_owns;

    assign is_reg   = (cpu_a == DMA_REG_ADDR);
    assign is_hram  = (cpu_a >= HRAM_LO) && (cpu_a <= HRAM_HI);
    assign cpu_owns = (!dma_active || is_hram || is_reg) && !dma_rd;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        bus_a    = 16'h0000;
        bus_dout = 8'h00;
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        cpu_din  = 8'hFF;
        if (dma_rd) begin
            bus_a  = dma_bus_a;
            bus_rd = 1'b1;
        end else if (cpu_owns) begin
            bus_a    = cpu_a;
            bus_dout = cpu_dout;
            bus_rd   = cpu_rd;
            bus_wr   = cpu_wr;
            cpu_din  = bus_din;
        end
        if (is_reg)
            cpu_din = src_hi;
    end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to DMA_REG_ADDR copies XFER_LEN bytes from {src_hi, 00} into OAM.
// Define OAM_DMA_ECHO_EN to redirect sources E0-FF onto echo RAM C0-DF.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
    parameter int          XFER_LEN     = XFER_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_dout,
    output logic        oam_wr,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state;
    logic [7:0] idx;
    logic [7:0] src_hi;
    logic [7:0] src_hi_eff;
    logic [7:0] data_q;
    logic       trigger;

    assign trigger = cpu_wr && (cpu_a == DMA_REG_ADDR);

`ifdef OAM_DMA_ECHO_EN
    assign src_hi_eff = echo_hi(src_hi);
`else
    assign src_hi_eff = src_hi;
`endif

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= 8'h00;
            src_hi <= 8'h00;
            data_q <= 8'h00;
        end else if (trigger) begin
            // A trigger in any state restarts from byte 0, abandoning any transfer in flight.
            src_hi <= cpu_dout;
            idx    <= 8'h00;
            state  <= START;
        end else begin
            case (state)
                START: state <= RD;
                RD: begin
                    data_q <= bus_din;
                    state  <= WR;
                end
                WR: begin
                    if (idx == LAST_IDX) begin
                        idx   <= 8'h00;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 8'h01;
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from state so an asynchronous reset silences OAM at once.
    assign dma_active = (state != IDLE);
    assign oam_wr     = (state == WR);
    assign oam_a      = oam_wr ? idx : 8'h00;
    assign oam_dout   = oam_wr ? data_q : 8'h00;

    oam_dma_cpu_gate #(
        .DMA_REG_ADDR(DMA_REG_ADDR)
    ) u_cpu_gate (
        .cpu_a     (cpu_a),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .dma_active(dma_active),
        .dma_rd    (state == RD),
        .dma_bus_a ({src_hi_eff, idx}),
        .src_hi    (src_hi),
        .bus_a     (bus_a),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr)
    );

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma; the bus model answers every read with the low address byte.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] bus_a;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  oam_a;
    logic [7:0]  oam_dout;
    logic        oam_wr;
    logic        dma_active;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];

    always #5 clk = ~clk;

    assign bus_din = bus_a[7:0];

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_a     (cpu_a),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .bus_a     (bus_a),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .oam_a     (oam_a),
        .oam_dout  (oam_dout),
        .oam_wr    (oam_wr),
        .dma_active(dma_active)
    );

    // Log DMA bus reads and OAM writes as they are committed.
    always @(posedge clk) begin
        if (dma_active && bus_rd && !cpu_rd)
            rd_log.push_back(bus_a);
        if (oam_wr)
            wr_log.push_back({oam_a, oam_dout});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic cpu_idle();
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
    endtask

    // Issue a DMA-register write at a negedge; edges restarts at the trigger edge.
    task automatic trigger(input logic [7:0] val);
        cpu_a    = 16'hFF46;
        cpu_dout = val;
        cpu_wr   = 1'b1;
        #1;
        check("trig_bus_wr", bus_wr, 1'b1);
        check("trig_bus_a", bus_a, 16'hFF46);
        tick();
        cpu_idle();
        edges = 0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (dma_active && n < limit) begin
            tick();
            n++;
        end
        check("idle_in_time", dma_active, 1'b0);
    endtask

    task automatic wait_oam(input logic [7:0] idx, input int limit);
        int n = 0;
        while (!(oam_wr && oam_a == idx) && n < limit) begin
            tick();
            n++;
        end
        check("reach_idx", {oam_wr, oam_a}, {1'b1, idx});
    endtask

    function automatic int rd_err(input int from, input int n, input logic [15:0] base);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (from + i >= rd_log.size() || rd_log[from + i] !== base + 16'(i))
                e++;
        return e;
    endfunction

    function automatic int wr_err(input int from, input int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (from + i >= wr_log.size() || wr_log[from + i] !== {8'(i), 8'(i)})
                e++;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0, wr0, wr_pre;
        logic [15:0] echo_base;

        cpu_idle();
        #12;
        check("rst_active", dma_active, 1'b0);
        check("rst_oam_wr", oam_wr, 1'b0);
        check("rst_oam_a", oam_a, 8'h00);
        check("rst_oam_dout", oam_dout, 8'h00);
        cpu_a  = 16'hFF46;
        cpu_rd = 1'b1;
        #1;
        check("rst_src_hi", cpu_din, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        cpu_idle();

        // Idle pass-through, write then read.
        cpu_a = 16'h1234; cpu_dout = 8'h5A; cpu_wr = 1'b1;
        #1;
        check("pass_wr_a", bus_a, 16'h1234);
        check("pass_wr_d", bus_dout, 8'h5A);
        check("pass_wr_s", {bus_wr, bus_rd}, 2'b10);
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_a = 16'hABCD;
        #1;
        check("pass_rd_s", {bus_wr, bus_rd}, 2'b01);
        check("pass_rd_d", cpu_din, 8'hCD);
        cpu_idle();
        tick();

        // Full transfer from C100 with CPU traffic during a WR cycle.
        rd0 = rd_log.size();
        wr0 = wr_log.size();
        trigger(8'hC1);
        check("start_active", dma_active, 1'b1);
        check("start_no_oam", oam_wr, 1'b0);
        wait_oam(8'd3, 20);
        cpu_a = 16'hC000; cpu_rd = 1'b1;
        #1;
        check("blk_rd_din", cpu_din, 8'hFF);
        check("blk_rd_bus", bus_rd, 1'b0);
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_dout = 8'h77;
        #1;
        check("blk_wr_bus", bus_wr, 1'b0);
        cpu_a = 16'hFF90; cpu_dout = 8'h3C;
        #1;
        check("hram_wr_s", bus_wr, 1'b1);
        check("hram_wr_a", bus_a, 16'hFF90);
        check("hram_wr_d", bus_dout, 8'h3C);
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_a = 16'hFF46;
        #1;
        check("reg_rd_dma", cpu_din, 8'hC1);
        cpu_idle();
        wait_idle(400);
        check("lat_c1", edges, 321);
        check("rd_cnt_c1", rd_log.size() - rd0, 160);
        check("rd_seq_c1", rd_err(rd0, 160, 16'hC100), 0);
        check("wr_cnt_c1", wr_log.size() - wr0, 160);
        check("wr_seq_c1", wr_err(wr0, 160), 0);

        // Retrigger at idx 50 switches the source to D000.
        wr_pre = wr_log.size();
        trigger(8'h80);
        wait_oam(8'd50, 200);
        trigger(8'hD0);
        check("pre_abort_wr", wr_err(wr_pre, 51), 0);
        check("pre_abort_cnt", wr_log.size() - wr_pre, 51);
        rd0 = rd_log.size();
        wr0 = wr_log.size();
        wait_idle(400);
        check("lat_d0", edges, 321);
        check("rd_first_d0", (rd0 < rd_log.size()) ? rd_log[rd0] : 16'hXXXX, 16'hD000);
        check("rd_seq_d0", rd_err(rd0, 160, 16'hD000), 0);
        check("wr_cnt_d0", wr_log.size() - wr0, 160);
        check("wr_seq_d0", wr_err(wr0, 160), 0);

        // Source E2 (echo-mapped when enabled), then async reset at idx 80.
`ifdef OAM_DMA_ECHO_EN
        echo_base = 16'hC200;
`else
        echo_base = 16'hE200;
`endif
        rd0 = rd_log.size();
        trigger(8'hE2);
        wait_oam(8'd80, 400);
        check("rd_first_e2", (rd0 < rd_log.size()) ? rd_log[rd0] : 16'hXXXX, echo_base);
        check("rd_seq_e2", rd_err(rd0, 81, echo_base), 0);
        rst = 1'b0;
        #1;
        check("arst_active", dma_active, 1'b0);
        check("arst_oam_wr", oam_wr, 1'b0);
        check("arst_oam_a", oam_a, 8'h00);
        wr0 = wr_log.size();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++)
            tick();
        check("arst_no_wr", wr_log.size() - wr0, 0);
        check("arst_idle", dma_active, 1'b0);
        cpu_a = 16'hFF46; cpu_rd = 1'b1;
        #1;
        check("arst_src_hi", cpu_din, 8'h00);
        cpu_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL expose parameter DMA_REG_ADDR, default 16'hFF46, address of the DMA source register.
REQ-002 SHALL expose parameter XFER_LEN, default 160, number of bytes copied per transfer.
REQ-003 SHALL have ports, clock and reset first:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- cpu_a, input, 16, CPU address.
- cpu_dout, input, 8, CPU write data.
- cpu_din, output, 8, read data returned to the CPU.
- cpu_rd, input, 1, CPU read strobe.
- cpu_wr, input, 1, CPU write strobe.
- bus_a, output, 16, system bus address.
- bus_dout, output, 8, system bus write data.
- bus_din, input, 8, system bus read data.
- bus_rd, output, 1, bus read strobe.
- bus_wr, output, 1, bus write strobe.
- oam_a, output, 8, OAM byte index.
- oam_dout, output, 8, OAM write data.
- oam_wr, output, 1, OAM write strobe.
- dma_active, output, 1, transfer in progress.

Function
REQ-004 SHALL, when idle, pass cpu_a, cpu_dout, cpu_rd and cpu_wr straight to the bus_* outputs, and pass bus_din to cpu_din, combinationally.
REQ-005 SHALL, on a clk edge where cpu_wr=1 and cpu_a=DMA_REG_ADDR, latch cpu_dout into src_hi and also forward that write to the bus.
REQ-006 SHALL return src_hi on cpu_din for a CPU read of DMA_REG_ADDR, in any state.
REQ-007 SHALL use states IDLE, START, RD and WR. A trigger write (REQ-005) moves IDLE to START; START moves to RD on the next edge; RD moves to WR; WR moves to RD, or to IDLE when idx = XFER_LEN-1.
REQ-008 SHALL, in RD, drive bus_a={src_hi_eff, idx} and bus_rd=1, and capture bus_din into a data register at the end of the cycle.
REQ-009 SHALL, in WR, drive oam_a=idx, oam_dout=the data register and oam_wr=1, then increment idx.
REQ-010 SHALL give a total latency of 1 + 2*XFER_LEN clk edges (321 at default) from the trigger edge to the return to IDLE.
REQ-011 SHALL hold dma_active=1 in START, RD and WR, and 0 in IDLE.
REQ-012 SHALL, while dma_active=1, pass CPU accesses in FF80-FFFE and DMA_REG_ADDR through.
- All other CPU reads SHALL return 8'hFF.
- All other CPU writes SHALL be dropped.
- CPU accesses SHALL never drive the bus_* outputs.
REQ-013 SHALL, on a trigger write during START, RD or WR, reload src_hi, clear idx to 0 and enter START; the interrupted transfer is abandoned.
REQ-014 SHALL hold oam_wr=0 outside WR, and bus_rd=0 and bus_wr=0 outside RD unless passing through a CPU access.
REQ-015 SHALL use an 8-bit idx, with comparison against XFER_LEN-1 only; no wrap beyond XFER_LEN.

Reset
REQ-016 SHALL, on rst=0, immediately set: state=IDLE, idx=0, src_hi=8'h00, data register=8'h00, dma_active=0, oam_wr=0, oam_a=0, oam_dout=0.
REQ-017 SHALL, when reset is asserted mid-transfer, abort with no further OAM writes; OAM contents already written are not reverted.

Configuration
REQ-018 SHALL, with OAM_DMA_ECHO_EN defined, set src_hi_eff = src_hi - 8'h20 for src_hi in E0-FF, mapping to echo RAM C0-DF.
REQ-019 SHALL, without OAM_DMA_ECHO_EN, set src_hi_eff = src_hi unconditionally.

Structure
REQ-020 SHALL place DMA_REG_ADDR default, HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE, XFER_LEN default and the state enum in a shared package, oam_dma_pkg.
REQ-021 SHALL isolate the CPU-side pass/block multiplexing (REQ-004, REQ-006, REQ-012) in one sub-module, oam_dma_cpu_gate. The FSM and datapath stay in oam_dma.

Verification
REQ-022 Write 8'hC1 to FF46, bus model returning low address byte -> 160 oam_wr pulses, oam_a 0..159 with oam_dout=oam_a; bus_a C100..C19F; dma_active low after 321 edges.
REQ-023 During DMA: CPU read of C000 -> cpu_din=FF; CPU write to FF90 -> reaches bus; CPU read of FF46 -> C1.
REQ-024 At idx=50, write 8'hD0 to FF46 -> next bus read at D000, full 160 bytes, total 321 edges from the second write.
REQ-025 With OAM_DMA_ECHO_EN, write 8'hE2 -> bus_a starts at C200. Without it -> E200.
REQ-026 rst=0 asynchronously at idx=80 -> dma_active=0 and oam_wr=0 within the same cycle; no further OAM writes after rst=1.
